// File: rtl/z80_pkg.sv
// Shared types for the Z80 bus machine-cycle sequencer: cycle kinds,
// T-state encoding and the idle (all-high) strobe bundle.
package z80_pkg;

  typedef enum logic [2:0] {
    CYC_OCF = 3'd0,
    CYC_MR  = 3'd1,
    CYC_MW  = 3'd2,
    CYC_PR  = 3'd3,
    CYC_PW  = 3'd4
  } cycle_t;

  typedef enum logic [2:0] {
    TS_IDLE = 3'd0,
    TS_T1   = 3'd1,
    TS_T2   = 3'd2,
    TS_TW   = 3'd3,
    TS_T3   = 3'd4,
    TS_T4   = 3'd5,
    TS_BGNT = 3'd6
  } tstate_t;

  typedef struct packed {
    logic m1_l;
    logic mreq_l;
    logic iorq_l;
    logic rd_l;
    logic wr_l;
    logic rfsh_l;
    logic busack_l;
  } strobes_t;

  localparam strobes_t STROBES_INACTIVE = '1;

  function automatic logic is_io(input cycle_t c);
    return (c == CYC_PR) || (c == CYC_PW);
  endfunction

endpackage

// File: rtl/z80_mcycle_seq.sv
// Machine-cycle sequencer: steps T-states for one bus cycle at a time,
// drives the active-low bus strobes and hands the bus away on BUSREQ_L.
module z80_mcycle_seq
  import z80_pkg::*;
(
  input  logic        clk,
  input  logic        rst_L,
  input  logic        start,
  output logic        ready,
  input  logic [2:0]  cyc_type,
  input  logic [15:0] addr_in,
  input  logic [7:0]  wdata_in,
  input  logic [15:0] rfsh_addr,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        rfsh_inc,
  input  logic [7:0]  data_in,
  output logic [15:0] addr_out,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        bus_oe,
  input  logic        WAIT_L,
  input  logic        BUSREQ_L,
  output logic        M1_L,
  output logic        MREQ_L,
  output logic        IORQ_L,
  output logic        RD_L,
  output logic        WR_L,
  output logic        RFSH_L,
  output logic        BUSACK_L,
  output logic [2:0]  dbg_state
);

  // Handshake: a cycle is accepted on a rising edge where start & ready and
  // BUSREQ_L is high; ready is high in IDLE and in the final T-state.
  tstate_t     state, state_nxt, end_nxt;
  cycle_t      cyc_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        final_st;
  logic        capture;
  strobes_t    stb;

  assign final_st = (state == TS_T4) || ((state == TS_T3) && (cyc_q != CYC_OCF));
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) state <= TS_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    end_nxt = TS_IDLE;
    if (!BUSREQ_L)  end_nxt = TS_BGNT;
    else if (start) end_nxt = TS_T1;

    state_nxt = state;
    case (state)
      TS_IDLE: begin
        if (!BUSREQ_L)  state_nxt = TS_BGNT;
        else if (start) state_nxt = TS_T1;
      end
      TS_T1:   state_nxt = TS_T2;
      TS_T2:   state_nxt = (is_io(cyc_q) || !WAIT_L) ? TS_TW : TS_T3;
      TS_TW:   state_nxt = WAIT_L ? TS_T3 : TS_TW;
      TS_T3:   state_nxt = (cyc_q == CYC_OCF) ? TS_T4 : end_nxt;
      TS_T4:   state_nxt = end_nxt;
      TS_BGNT: if (BUSREQ_L) state_nxt = TS_IDLE;
      default: state_nxt = TS_IDLE;
    endcase
  end

  // Opcode fetches latch data before refresh; reads latch at the end of T3.
  assign capture = ((cyc_q == CYC_OCF) && ((state == TS_T2) || (state == TS_TW))
                    && (state_nxt == TS_T3))
                 || (((cyc_q == CYC_MR) || (cyc_q == CYC_PR)) && (state == TS_T3));

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      cyc_q   <= CYC_OCF;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
    end else begin
      if (state_nxt == TS_T1) begin
        cyc_q   <= cycle_t'(cyc_type);
        addr_q  <= addr_in;
        wdata_q <= wdata_in;
      end
      if (capture) rdata <= data_in;
    end
  end

  always_comb begin
    stb      = STROBES_INACTIVE;
    data_oe  = 1'b0;
    bus_oe   = 1'b1;
    addr_out = addr_q;
    ready    = final_st;
    done     = final_st;
    rfsh_inc = (state == TS_T4);
    case (state)
      TS_IDLE: ready = 1'b1;
      TS_T1, TS_T2, TS_TW, TS_T3, TS_T4: begin
        case (cyc_q)
          CYC_OCF: begin
            if (state == TS_T3 || state == TS_T4) begin
              stb.rfsh_l = 1'b0;
              addr_out   = rfsh_addr;
              if (state == TS_T3) stb.mreq_l = 1'b0;
            end else begin
              stb.m1_l   = 1'b0;
              stb.mreq_l = 1'b0;
              stb.rd_l   = 1'b0;
            end
          end
          CYC_MR: begin
            stb.mreq_l = 1'b0;
            stb.rd_l   = 1'b0;
          end
          CYC_MW: begin
            stb.mreq_l = 1'b0;
            data_oe    = 1'b1;
            if (state != TS_T1) stb.wr_l = 1'b0;
          end
          CYC_PR: begin
            if (state != TS_T1) begin
              stb.iorq_l = 1'b0;
              stb.rd_l   = 1'b0;
            end
          end
          CYC_PW: begin
            data_oe = 1'b1;
            if (state != TS_T1) begin
              stb.iorq_l = 1'b0;
              stb.wr_l   = 1'b0;
            end
          end
          default: ;
        endcase
      end
      TS_BGNT: begin
        stb.busack_l = 1'b0;
        bus_oe       = 1'b0;
      end
      default: ;
    endcase
  end

  assign data_out = wdata_q;
  assign M1_L     = stb.m1_l;
  assign MREQ_L   = stb.mreq_l;
  assign IORQ_L   = stb.iorq_l;
  assign RD_L     = stb.rd_l;
  assign WR_L     = stb.wr_l;
  assign RFSH_L   = stb.rfsh_l;
  assign BUSACK_L = stb.busack_l;

endmodule

// File: tb/tb_z80_mcycle_seq.sv
// Bench for z80_mcycle_seq: directed scenarios plus randomized cycle streams
// checked clock-by-clock against a per-cycle timeline model.
module tb_z80_mcycle_seq;
  import z80_pkg::*;

  logic        clk = 1'b0;
  logic        rst_L;
  logic        start;
  logic        ready;
  logic [2:0]  cyc_type;
  logic [15:0] addr_in;
  logic [7:0]  wdata_in;
  logic [15:0] rfsh_addr;
  logic        done;
  logic [7:0]  rdata;
  logic        rfsh_inc;
  logic [7:0]  data_in;
  logic [15:0] addr_out;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        bus_oe;
  logic        WAIT_L;
  logic        BUSREQ_L;
  logic        M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L, BUSACK_L;
  logic [2:0]  dbg_state;

  z80_mcycle_seq dut (
    .clk(clk), .rst_L(rst_L), .start(start), .ready(ready),
    .cyc_type(cyc_type), .addr_in(addr_in), .wdata_in(wdata_in),
    .rfsh_addr(rfsh_addr), .done(done), .rdata(rdata), .rfsh_inc(rfsh_inc),
    .data_in(data_in), .addr_out(addr_out), .data_out(data_out),
    .data_oe(data_oe), .bus_oe(bus_oe), .WAIT_L(WAIT_L), .BUSREQ_L(BUSREQ_L),
    .M1_L(M1_L), .MREQ_L(MREQ_L), .IORQ_L(IORQ_L), .RD_L(RD_L), .WR_L(WR_L),
    .RFSH_L(RFSH_L), .BUSACK_L(BUSACK_L), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  cyc;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  din;
    int          nwait;
    bit          breq;
  } txn_t;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_rdata = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs_ctl();
    return {20'd0, M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L, BUSACK_L,
            done, rfsh_inc, ready, data_oe, bus_oe};
  endfunction

  // Flags are "asserted" (1 = strobe low / output active).
  function automatic logic [31:0] mk_ctl(input bit m1, input bit mreq, input bit iorq,
                                         input bit rd, input bit wr, input bit rfsh,
                                         input bit back, input bit dn, input bit ri,
                                         input bit rdy, input bit doe, input bit boe);
    return {20'd0, ~m1, ~mreq, ~iorq, ~rd, ~wr, ~rfsh, ~back, dn, ri, rdy, doe, boe};
  endfunction

  function automatic txn_t gen_txn();
    txn_t t;
    t.cyc   = 3'($urandom_range(0, 4));
    t.addr  = 16'($urandom);
    t.wdata = 8'($urandom);
    t.din   = 8'($urandom);
    t.nwait = $urandom_range(0, 3);
    t.breq  = 1'b0;
    return t;
  endfunction

  // driver tasks
  task automatic apply(input txn_t t);
    cyc_type = t.cyc;
    addr_in  = t.addr;
    wdata_in = t.wdata;
  endtask

  task automatic check_rdata();
    if (exp_q.size() > 0) begin
      exp_rdata = exp_q.pop_front();
      check("rdata_cap", 32'(rdata), 32'(exp_rdata));
    end else begin
      check("rdata_hold", 32'(rdata), 32'(exp_rdata));
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check(tag, obs_ctl(), mk_ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    check_rdata();
    @(posedge clk); #1;
  endtask

  task automatic check_bgnt(input string tag);
    @(negedge clk);
    check(tag, obs_ctl(), mk_ctl(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    check_rdata();
    @(posedge clk); #1;
  endtask

  // Called just after the accept edge; walks clock k = 1..len of the cycle.
  task automatic run_clocks(input txn_t t, input bit chain, input txn_t nx);
    bit ocf, io, m1, mreq, iorq, rd, wr, rfsh, doe;
    int w, t3, len, cap_k;
    logic [15:0] a_exp;
    ocf   = (t.cyc == CYC_OCF);
    io    = (t.cyc == CYC_PR) || (t.cyc == CYC_PW);
    w     = io ? t.nwait + 1 : t.nwait;
    t3    = 3 + w;
    len   = ocf ? t3 + 1 : t3;
    cap_k = ocf ? t3 - 1 : ((t.cyc == CYC_MR) || (t.cyc == CYC_PR)) ? len : 0;
    for (int k = 1; k <= len; k++) begin
      if (k >= 2 && k <= t3 - 1) WAIT_L = (k == t3 - 1);
      else WAIT_L = 1'($urandom_range(0, 1));
      if (io && k == 2) WAIT_L = 1'($urandom_range(0, 1));
      data_in = (k == cap_k) ? t.din : 8'($urandom);
      if (t.breq && k >= 2) BUSREQ_L = 1'b0;
      if (chain && k == len) begin
        start = 1'b1;
        apply(nx);
      end
      @(negedge clk);
      {m1, mreq, iorq, rd, wr, rfsh, doe} = '0;
      a_exp = t.addr;
      if (ocf) begin
        if (k < t3) {m1, mreq, rd} = 3'b111;
        else begin
          rfsh  = 1'b1;
          mreq  = (k == t3);
          a_exp = rfsh_addr;
        end
      end else if (t.cyc == CYC_MR) begin
        {mreq, rd} = 2'b11;
      end else if (t.cyc == CYC_MW) begin
        mreq = 1'b1;
        wr   = (k >= 2);
        doe  = 1'b1;
      end else if (t.cyc == CYC_PR) begin
        iorq = (k >= 2);
        rd   = (k >= 2);
      end else begin
        iorq = (k >= 2);
        wr   = (k >= 2);
        doe  = 1'b1;
      end
      check("ctl", obs_ctl(),
            mk_ctl(m1, mreq, iorq, rd, wr, rfsh, 0, k == len, ocf && k == len,
                   k == len, doe, 1));
      check("addr", 32'(addr_out), 32'(a_exp));
      if (doe) check("wdata", 32'(data_out), 32'(t.wdata));
      check_rdata();
      @(posedge clk); #1;
      if (k == cap_k) exp_q.push_back(t.din);
      if (chain && k == len) start = 1'b0;
    end
  endtask

  task automatic launch(input txn_t t);
    start = 1'b1;
    apply(t);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    txn_t t, t1, t2, cur, nxt;
    bit chain;
    rst_L = 1'b0; start = 1'b0; WAIT_L = 1'b1; BUSREQ_L = 1'b1;
    cyc_type = '0; addr_in = '0; wdata_in = '0; rfsh_addr = '0; data_in = '0;
    #2;
    check("rst_ctl", obs_ctl(), mk_ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    check("rst_addr", 32'(addr_out), 32'd0);
    check("rst_dout", 32'(data_out), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(TS_IDLE));
    @(posedge clk); @(posedge clk); #1;
    rst_L = 1'b1;
    check_idle("idle");

    // opcode fetch, no wait
    rfsh_addr = 16'h3F05;
    t = '{3'(CYC_OCF), 16'h0100, 8'h00, 8'hC3, 0, 1'b0};
    launch(t);
    run_clocks(t, 1'b0, t);
    check_idle("idle_ocf");

    // memory read with two waits
    t = '{3'(CYC_MR), 16'h4000, 8'h00, 8'h9E, 2, 1'b0};
    launch(t);
    run_clocks(t, 1'b0, t);
    check_idle("idle_mr");

    // port write, forced wait only
    t = '{3'(CYC_PW), 16'h00FE, 8'h5A, 8'h00, 0, 1'b0};
    launch(t);
    run_clocks(t, 1'b0, t);
    check_idle("idle_pw");

    // bus request during MR T2: cycle completes, then grant
    t = '{3'(CYC_MR), 16'h8001, 8'h00, 8'h37, 0, 1'b1};
    launch(t);
    run_clocks(t, 1'b0, t);
    check_bgnt("bgnt");
    start = 1'b1;
    check_bgnt("bgnt_start");
    start = 1'b0;
    BUSREQ_L = 1'b1;
    check_bgnt("bgnt_rel");
    check_idle("idle_after_bgnt");

    // bus request in IDLE beats start
    BUSREQ_L = 1'b0;
    start = 1'b1;
    apply(gen_txn());
    check_idle("idle_breq");
    check_bgnt("bgnt_idle");
    BUSREQ_L = 1'b1;
    check_bgnt("bgnt_idle_rel");
    start = 1'b0;
    check_idle("idle_after_bgnt2");

    // three back-to-back memory writes
    t  = '{3'(CYC_MW), 16'h2000, 8'h11, 8'h00, 0, 1'b0};
    t1 = '{3'(CYC_MW), 16'h2001, 8'h22, 8'h00, 0, 1'b0};
    t2 = '{3'(CYC_MW), 16'h2002, 8'h33, 8'h00, 0, 1'b0};
    launch(t);
    run_clocks(t, 1'b1, t1);
    run_clocks(t1, 1'b1, t2);
    run_clocks(t2, 1'b0, t2);
    check_idle("idle_b2b");

    // randomized streams
    for (int b = 0; b < 10; b++) begin
      chain = 1'($urandom_range(0, 1));
      rfsh_addr = 16'($urandom);
      cur = gen_txn();
      launch(cur);
      for (int i = 0; i < 5; i++) begin
        nxt = gen_txn();
        run_clocks(cur, chain && (i < 4), nxt);
        if (!chain && i < 4) begin
          start = 1'b1;
          apply(nxt);
          check_idle("idle_gap");
          start = 1'b0;
        end
        cur = nxt;
      end
      check_idle("idle_batch");
    end

    // reset during OCF wait state
    t = '{3'(CYC_OCF), 16'h1234, 8'h00, 8'h00, 3, 1'b0};
    launch(t);
    WAIT_L = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    rst_L = 1'b0;
    #1;
    exp_q.delete();
    exp_rdata = 8'h00;
    check("rst_mid_ctl", obs_ctl(), mk_ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    check("rst_mid_addr", 32'(addr_out), 32'd0);
    check("rst_mid_rdata", 32'(rdata), 32'd0);
    @(negedge clk);
    check("rst_hold_ctl", obs_ctl(), mk_ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    @(posedge clk); #1;
    rst_L = 1'b1;
    WAIT_L = 1'b1;
    check_idle("idle_post_rst");
    check("post_rst_state", 32'(dbg_state), 32'(TS_IDLE));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/z80_mcycle_seq.md
# z80_mcycle_seq

Machine-cycle sequencer for the Z80 core's external bus. The control FSM requests one machine cycle at a time (opcode fetch, memory read/write, port read/write). This block steps the T-states, drives the bus strobes and address/data enables, and inserts wait states. It also arbitrates bus ownership against external BUSREQ_L. It sits between control_fsm and the top-level pins and is the sole driver of the bus strobes.

## Interface
- clk  in  1  core clock; one T-state per rising edge
- rst_L  in  1  reset, asynchronous, active-low
- start  in  1  request a machine cycle; accepted when start & ready
- ready  out  1  sequencer can accept a cycle this clock
- cyc_type  in  3  z80_pkg::cycle_t: CYC_OCF, CYC_MR, CYC_MW, CYC_PR, CYC_PW; sampled on accept
- addr_in  in  16  cycle address; sampled on accept
- wdata_in  in  8  write data for MW/PW; sampled on accept
- rfsh_addr  in  16  {I,R} refresh address from the register file
- done  out  1  one-cycle pulse in the final T-state of a cycle
- rdata  out  8  data captured from data_in; held until the next capture
- rfsh_inc  out  1  one-cycle pulse in OCF T4; increments R
- data_in  in  8  bus data
- addr_out  out  16  bus address
- data_out  out  8  bus write data
- data_oe  out  1  drive data_out onto the bus
- bus_oe  out  1  drive addr_out and strobes; 0 while bus is granted away
- WAIT_L, BUSREQ_L  in  1  pin inputs
- M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L, BUSACK_L  out  1  pin strobes, active-low

## Operation
- States: IDLE, T1, T2, TW, T3, T4, BGNT. Outputs are decoded from the state register plus the latched cycle type.
- Strobes, low in these states:
  - OCF: M1_L, MREQ_L and RD_L in T1, T2, TW. In T3 and T4, RFSH_L=0 and addr_out=rfsh_addr. MREQ_L is low in T3 only.
  - MR: MREQ_L and RD_L in T1–T3.
  - MW: MREQ_L in T1–T3; WR_L in T2–T3; data_oe in T1–T3.
  - PR: IORQ_L and RD_L in T2, TW, T3.
  - PW: IORQ_L and WR_L in T2, TW, T3; data_oe in T1–T3.
- addr_out holds the latched address from T1 through the final T-state, except during OCF refresh.
- Transitions:
  - IDLE→T1 on accept; T1→T2.
  - T2→TW if WAIT_L=0, else T3. PR/PW always go T2→TW for one forced wait.
  - TW→TW while WAIT_L=0, else T3.
  - T3→T4 for OCF only; for all other cycles T3 is the final state.
- Final state:
  - done=1 and ready=1.
  - If BUSREQ_L=0, next state is BGNT; start is ignored.
  - Else if start=1, next state is T1 (back-to-back cycle).
  - Else next state is IDLE.
- IDLE: ready=1. BUSREQ_L=0 goes to BGNT and has priority over start.
- BGNT: BUSACK_L=0, bus_oe=0, data_oe=0, ready=0. Return to IDLE the cycle after BUSREQ_L is sampled 1.
- rdata capture edge:
  - OCF: the edge leaving T2/TW.
  - MR/PR: the edge leaving T3.
- BUSREQ_L is never honoured mid-cycle.

## Timing
- Reset (asynchronous, immediate): state=IDLE. All strobes including BUSACK_L =1. bus_oe=1, data_oe=0, done=0, rfsh_inc=0, ready=1, addr_out=0, data_out=0, rdata=0.
- Reset mid-cycle aborts the cycle with no done pulse.
- WAIT_L is sampled only on the edge leaving T2 or TW.
- Zero-wait latency, counted from the accept edge to done high:
  - OCF: 4 clocks (done in T4).
  - MR/MW: 3 clocks.
  - PR/PW: 4 clocks.
- Each sampled WAIT_L=0 adds one clock.
- Back-to-back throughput: no idle clock between cycles.

## Structure
- z80_pkg holds:
  - cycle_t enum, 3 bits;
  - tstate_t enum for IDLE..BGNT;
  - the strobe-inactive constant bundle.
- The module is a single, flat block. Sub-modules buy nothing: strobe decode is a case on {state, cyc_type}.

## Test plan
- OCF, addr_in=16'h0100, rfsh_addr=16'h3F05, data_in=8'hC3, WAIT_L=1:
  - M1_L/MREQ_L/RD_L low for 2 clocks, then addr_out=3F05 with RFSH_L low for 2 clocks;
  - rdata=C3; done and rfsh_inc pulse on the 4th clock.
- MR with WAIT_L=0 on two samples: exactly 2 TW states, done on the 5th clock, rdata=data_in at the T3 exit.
- PW to 16'h00FE, data 8'h5A, WAIT_L=1:
  - IORQ_L/WR_L low for 3 clocks (T2, forced TW, T3), data_oe high for 4 clocks, data_out=5A;
  - done on the 4th clock.
- BUSREQ_L asserted during MR T2: the cycle completes normally, then BGNT: BUSACK_L=0, bus_oe=0, ready=0. BUSREQ_L released → IDLE one clock later.
- start held high across three MW cycles with BUSREQ_L=1: T1 follows each T3 directly, giving 9 consecutive clocks and 3 done pulses.
- rst_L dropped in OCF TW: all strobes go high immediately, no done pulse, state=IDLE after release.
